// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues pipelined requests to a
// variable-latency in-order memory, and buffers responses for decode.
module fetch_unit #(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 16,
  parameter int                BUF_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                PC_INC    = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [ADDR_W-1:0] instr_pc_next,
  output logic              err
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SUM_W = CNT_W + 2;
  localparam logic [ADDR_W-1:0] INC = ADDR_W'(PC_INC);

  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [CNT_W-1:0]  out_cnt_reg, out_cnt_next;
  logic [CNT_W-1:0]  disc_cnt_reg, disc_cnt_next;
  logic [CNT_W-1:0]  fifo_cnt_reg, fifo_cnt_next;
  logic [PTR_W-1:0]  fifo_rd_reg, fifo_rd_next, fifo_wr_reg, fifo_wr_next;
  logic [PTR_W-1:0]  tag_rd_reg, tag_rd_next, tag_wr_reg, tag_wr_next;
  logic              err_reg, err_next;

  logic [DATA_W-1:0] fifo_instr_mem [BUF_DEPTH];
  logic [ADDR_W-1:0] fifo_pc_mem    [BUF_DEPTH];
  logic [ADDR_W-1:0] tag_mem        [BUF_DEPTH];

  logic [SUM_W-1:0]  credit_sum;
  logic              credit_ok, issue, rsp_drop, rsp_accept, rsp_unexp, deq;

  // In-flight, buffered and to-be-discarded slots all share one budget so the FIFO cannot overflow.
  assign credit_sum = SUM_W'(out_cnt_reg) + SUM_W'(fifo_cnt_reg) + SUM_W'(disc_cnt_reg);
  assign credit_ok  = credit_sum < SUM_W'(BUF_DEPTH);
  assign imem_req   = credit_ok & ~halt & ~redirect & rst;
  assign imem_addr  = pc_reg;
  assign issue      = credit_ok & ~halt & ~redirect & imem_gnt;

  assign rsp_drop   = imem_rvalid & (disc_cnt_reg != '0);
  assign rsp_unexp  = imem_rvalid & (disc_cnt_reg == '0) & (out_cnt_reg == '0);
  assign rsp_accept = imem_rvalid & (disc_cnt_reg == '0) & (out_cnt_reg != '0) & ~redirect;

  assign instr_valid   = (fifo_cnt_reg != '0);
  assign deq           = instr_valid & instr_ready;
  assign instr         = instr_valid ? fifo_instr_mem[fifo_rd_reg] : '0;
  assign instr_pc      = instr_valid ? fifo_pc_mem[fifo_rd_reg] : '0;
  assign instr_pc_next = instr_valid ? fifo_pc_mem[fifo_rd_reg] + INC : '0;
  assign err           = err_reg;

  always_comb begin
    pc_next       = pc_reg;
    out_cnt_next  = out_cnt_reg;
    disc_cnt_next = disc_cnt_reg;
    fifo_cnt_next = fifo_cnt_reg;
    fifo_rd_next  = fifo_rd_reg;
    fifo_wr_next  = fifo_wr_reg;
    tag_rd_next   = tag_rd_reg;
    tag_wr_next   = tag_wr_reg;
    err_next      = err_reg | rsp_unexp;

    if (redirect) begin
      // Everything still in flight becomes stale; a response landing now is one of them.
      err_next      = err_reg | rsp_unexp | redirect_pc[0];
      pc_next       = {redirect_pc[ADDR_W-1:1], 1'b0};
      disc_cnt_next = out_cnt_reg + disc_cnt_reg - CNT_W'(imem_rvalid & ~rsp_unexp);
      out_cnt_next  = '0;
      fifo_cnt_next = '0;
      fifo_rd_next  = '0;
      fifo_wr_next  = '0;
      tag_rd_next   = '0;
      tag_wr_next   = '0;
    end else begin
      if (issue) begin
        pc_next     = pc_reg + INC;
        tag_wr_next = tag_wr_reg + 1'b1;
      end
      if (rsp_drop) disc_cnt_next = disc_cnt_reg - 1'b1;
      if (rsp_accept) begin
        tag_rd_next  = tag_rd_reg + 1'b1;
        fifo_wr_next = fifo_wr_reg + 1'b1;
      end
      if (deq) fifo_rd_next = fifo_rd_reg + 1'b1;
      out_cnt_next  = out_cnt_reg + CNT_W'(issue) - CNT_W'(rsp_accept);
      fifo_cnt_next = fifo_cnt_reg + CNT_W'(rsp_accept) - CNT_W'(deq);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_reg       <= RESET_PC;
      out_cnt_reg  <= '0;
      disc_cnt_reg <= '0;
      fifo_cnt_reg <= '0;
      fifo_rd_reg  <= '0;
      fifo_wr_reg  <= '0;
      tag_rd_reg   <= '0;
      tag_wr_reg   <= '0;
      err_reg      <= 1'b0;
    end else begin
      pc_reg       <= pc_next;
      out_cnt_reg  <= out_cnt_next;
      disc_cnt_reg <= disc_cnt_next;
      fifo_cnt_reg <= fifo_cnt_next;
      fifo_rd_reg  <= fifo_rd_next;
      fifo_wr_reg  <= fifo_wr_next;
      tag_rd_reg   <= tag_rd_next;
      tag_wr_reg   <= tag_wr_next;
      err_reg      <= err_next;
    end
  end

  // Storage needs no reset; validity is tracked by the counters and pointers.
  always_ff @(posedge clk) begin
    if (issue) tag_mem[tag_wr_reg] <= pc_reg;
    if (rsp_accept) begin
      fifo_instr_mem[fifo_wr_reg] <= imem_rdata;
      fifo_pc_mem[fifo_wr_reg]    <= tag_mem[tag_rd_reg];
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order memory model plus a queue-based
// reference of the fetch front end, compared against the DUT every cycle.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [15:0] imem_addr, imem_rdata;
  logic        redirect, halt, instr_valid, instr_ready, err;
  logic [15:0] redirect_pc, instr, instr_pc, instr_pc_next;

  fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .instr_pc(instr_pc), .instr_pc_next(instr_pc_next), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // stimulus knobs
  int  p_gnt = 100, p_ready = 100, p_rsp = 100, p_redir = 0, lat_min = 1, lat_max = 1;
  bit  k_halt = 0, odd_ok = 0, rst_hold = 0, force_redirect = 0, force_spurious = 0;
  logic [15:0] force_rpc = 16'h0;

  // memory model: accepted requests awaiting their response
  logic [15:0] mem_addr_q [$];
  int          mem_due_q  [$];

  // reference model of the fetch unit
  logic [15:0] m_pcreg = 16'h0;
  logic [15:0] m_inflight [$];
  logic [15:0] m_instr [$];
  logic [15:0] m_pc [$];
  int          m_disc = 0;
  bit          m_err = 0;

  function automatic logic [15:0] mem_data(input logic [15:0] a);
    return (a * 16'd7) ^ 16'h5A3C;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit model_req();
    return (m_inflight.size() + m_instr.size() + m_disc < 4) && !halt && !redirect;
  endfunction

  task automatic model_reset();
    m_pcreg = 16'h0;
    m_inflight.delete(); m_instr.delete(); m_pc.delete();
    m_disc = 0; m_err = 0;
    mem_addr_q.delete(); mem_due_q.delete();
  endtask

  // Drive this cycle's inputs just after the edge, then wait for the sampling edge.
  task automatic begin_cycle();
    @(posedge clk); #1;
    cyc++;
    rst         = !rst_hold;
    instr_ready = ($urandom_range(0, 99) < p_ready);
    imem_gnt    = ($urandom_range(0, 99) < p_gnt);
    halt        = k_halt;
    if (force_redirect) begin
      redirect = 1'b1; redirect_pc = force_rpc; force_redirect = 0;
    end else begin
      redirect    = ($urandom_range(0, 99) < p_redir);
      redirect_pc = 16'($urandom);
      if (!odd_ok) redirect_pc[0] = 1'b0;
    end
    imem_rvalid = 1'b0;
    imem_rdata  = 16'($urandom);
    if (rst) begin
      if (mem_addr_q.size() > 0 && mem_due_q[0] <= cyc && $urandom_range(0, 99) < p_rsp) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_data(mem_addr_q.pop_front());
        void'(mem_due_q.pop_front());
      end else if (force_spurious && mem_addr_q.size() == 0) begin
        imem_rvalid = 1'b1; imem_rdata = 16'hDEAD; force_spurious = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic check_model();
    bit v;
    logic [15:0] pn;
    if (!rst) return;
    v  = (m_instr.size() > 0);
    pn = v ? m_pc[0] + 16'd2 : 16'h0;
    chk("imem_req", 32'(imem_req), 32'(model_req()));
    chk("imem_addr", 32'(imem_addr), 32'(m_pcreg));
    chk("instr_valid", 32'(instr_valid), 32'(v));
    chk("instr", 32'(instr), v ? 32'(m_instr[0]) : 32'h0);
    chk("instr_pc", 32'(instr_pc), v ? 32'(m_pc[0]) : 32'h0);
    chk("instr_pc_next", 32'(instr_pc_next), 32'(pn));
    chk("err", 32'(err), 32'(m_err));
  endtask

  // Advance the model over the clock edge that ends this cycle.
  task automatic end_cycle();
    bit iss, rsp, live;
    logic [15:0] t;
    if (!rst) begin model_reset(); return; end
    iss  = model_req() && imem_gnt;
    rsp  = imem_rvalid;
    live = (m_inflight.size() + m_disc) > 0;
    if (m_instr.size() > 0 && instr_ready) begin
      void'(m_instr.pop_front()); void'(m_pc.pop_front());
    end
    if (rsp && !live) m_err = 1;
    if (redirect) begin
      if (redirect_pc[0]) m_err = 1;
      m_disc = m_inflight.size() + m_disc - ((rsp && live) ? 1 : 0);
      m_inflight.delete(); m_instr.delete(); m_pc.delete();
      m_pcreg = redirect_pc & 16'hFFFE;
    end else if (rsp && live) begin
      if (m_disc > 0) m_disc--;
      else begin
        t = m_inflight.pop_front();
        m_instr.push_back(mem_data(t));
        m_pc.push_back(t);
      end
    end
    if (iss) begin
      mem_addr_q.push_back(m_pcreg);
      mem_due_q.push_back(cyc + $urandom_range(lat_min, lat_max));
      m_inflight.push_back(m_pcreg);
      m_pcreg = m_pcreg + 16'd2;
    end
  endtask

  task automatic step();
    begin_cycle(); check_model(); end_cycle();
  endtask

  task automatic do_reset(input int n);
    rst_hold = 1;
    for (int i = 0; i < n; i++) begin
      begin_cycle();
      if (i == 0) begin
        chk("rst_instr_valid", 32'(instr_valid), 32'h0);
        chk("rst_imem_req", 32'(imem_req), 32'h0);
        chk("rst_imem_addr", 32'(imem_addr), 32'h0);
        chk("rst_instr", 32'(instr), 32'h0);
        chk("rst_instr_pc", 32'(instr_pc), 32'h0);
        chk("rst_instr_pc_next", 32'(instr_pc_next), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
      end
      end_cycle();
    end
    rst_hold = 0;
  endtask

  task automatic directed_knobs(input int lat);
    p_gnt = 100; p_ready = 100; p_rsp = 100; p_redir = 0;
    lat_min = lat; lat_max = lat; k_halt = 0; odd_ok = 0;
  endtask

  // Run up to n cycles and check the pc of the first valid instruction.
  task automatic first_valid(input string name, input int n, input logic [15:0] exp_pc);
    bit found = 0;
    for (int i = 0; i < n; i++) begin
      begin_cycle(); check_model();
      if (!found && instr_valid) begin
        found = 1;
        chk(name, 32'(instr_pc), 32'(exp_pc));
      end
      end_cycle();
    end
    chk({name, "_found"}, 32'(found), 32'h1);
  endtask

  initial begin
    int n_iss, n_deq;
    redirect = 0; redirect_pc = 0; halt = 0; instr_ready = 0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;

    // 1: streaming with a 1-cycle memory
    directed_knobs(1);
    do_reset(3);
    for (int i = 0; i < 8; i++) begin
      begin_cycle(); check_model();
      if (i < 3) chk("t1_addr", 32'(imem_addr), 32'(2 * i));
      if (i == 1) chk("t1_not_yet_valid", 32'(instr_valid), 32'h0);
      if (i == 2) begin
        chk("t1_first_valid", 32'(instr_valid), 32'h1);
        chk("t1_first_pc_next", 32'(instr_pc_next), 32'h2);
        chk("t1_first_instr", 32'(instr), 32'(mem_data(16'h0)));
      end
      if (i >= 2) chk("t1_stream_pc", 32'(instr_pc), 32'(2 * (i - 2)));
      end_cycle();
    end

    // 2: decode stalled, credit limits to BUF_DEPTH requests
    directed_knobs(1); p_ready = 0;
    do_reset(2);
    n_iss = 0;
    for (int i = 0; i < 10; i++) begin
      begin_cycle(); check_model();
      if (imem_req && imem_gnt) n_iss++;
      end_cycle();
    end
    chk("t2_issued", 32'(n_iss), 32'h4);
    p_ready = 100;
    for (int j = 0; j < 4; j++) begin
      begin_cycle(); check_model();
      chk("t2_drain_pc", 32'(instr_pc), 32'(2 * j));
      if (j == 0) chk("t2_req_stalled", 32'(imem_req), 32'h0);
      if (j == 1) begin
        chk("t2_req_resume", 32'(imem_req), 32'h1);
        chk("t2_addr_resume", 32'(imem_addr), 32'h8);
      end
      end_cycle();
    end

    // 3: redirect with two fetches in flight (latency 3)
    directed_knobs(3);
    do_reset(2);
    step(); step();
    force_redirect = 1; force_rpc = 16'h0100;
    begin_cycle(); check_model();
    chk("t3_req_in_redirect", 32'(imem_req), 32'h0);
    end_cycle();
    begin_cycle(); check_model();
    chk("t3_addr_after", 32'(imem_addr), 32'h0100);
    end_cycle();
    first_valid("t3_first_pc", 14, 16'h0100);

    // 4: misaligned redirect
    directed_knobs(1);
    do_reset(2);
    force_redirect = 1; force_rpc = 16'h0101;
    step();
    begin_cycle(); check_model();
    chk("t4_err", 32'(err), 32'h1);
    chk("t4_addr", 32'(imem_addr), 32'h0100);
    end_cycle();
    first_valid("t4_first_pc", 8, 16'h0100);
    chk("t4_err_sticky", 32'(err), 32'h1);

    // 5: PC wrap-around
    directed_knobs(1);
    do_reset(2);
    force_redirect = 1; force_rpc = 16'hFFFE;
    step();
    begin_cycle(); check_model();
    chk("t5_addr_fffe", 32'(imem_addr), 32'hFFFE);
    end_cycle();
    begin_cycle(); check_model();
    chk("t5_addr_wrap", 32'(imem_addr), 32'h0000);
    end_cycle();
    begin_cycle(); check_model();
    chk("t5_head_pc", 32'(instr_pc), 32'hFFFE);
    chk("t5_head_pc_next", 32'(instr_pc_next), 32'h0000);
    end_cycle();

    // 6: halt with two outstanding, then a spurious response
    directed_knobs(3);
    do_reset(2);
    step(); step();
    k_halt = 1;
    n_deq = 0;
    for (int i = 0; i < 10; i++) begin
      begin_cycle(); check_model();
      chk("t6_req_halted", 32'(imem_req), 32'h0);
      if (instr_valid && instr_ready) begin
        chk("t6_deq_pc", 32'(instr_pc), 32'(2 * n_deq));
        n_deq++;
      end
      end_cycle();
    end
    chk("t6_drained", 32'(n_deq), 32'h2);
    chk("t6_err_before", 32'(err), 32'h0);
    force_spurious = 1;
    step();
    begin_cycle(); check_model();
    chk("t6_err_spurious", 32'(err), 32'h1);
    end_cycle();
    k_halt = 0;

    // 7: randomized traffic; each round starts with a reset mid-operation
    for (int r = 0; r < 6; r++) begin
      do_reset(2);
      p_gnt = $urandom_range(30, 100); p_ready = $urandom_range(20, 100);
      p_rsp = $urandom_range(30, 100); lat_min = 1; lat_max = $urandom_range(1, 6);
      p_redir = $urandom_range(0, 8); odd_ok = (r == 5);
      for (int i = 0; i < 400; i++) begin
        k_halt = ($urandom_range(0, 99) < 10);
        step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
